jk_cmd_arbiter: RTL



---
 rtl/jk_cmd_pkg.sv | 29 ++
 rtl/jk_rr_arbiter.sv | 72 +++++++
 rtl/jk_cmd_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/jk_cmd_pkg.sv
// jk_cmd_pkg: shared definitions for the JK command arbiter.
//   OP_*    : 2-bit {j,k} command codes
//   state_t : arbiter FSM encoding
//   jk_next : next value of one JK bit for a given op
package jk_cmd_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } state_t;

  function automatic logic jk_next(input logic [1:0] op, input logic qb);
    logic nb;
    nb = qb;
    case (op)
      OP_CLR:  nb = 1'b0;
      OP_SET:  nb = 1'b1;
      OP_TGL:  nb = ~qb;
      default: nb = qb;
    endcase
    return nb;
  endfunction

endpackage

// File: rtl/jk_rr_arbiter.sv
// jk_rr_arbiter: picks one winner among the active requests.
//   Default build: round-robin, search starts at r_ptr; r_ptr moves to
//   winner+1 (wrapping) whenever i_adv is high.
//   JK_ARB_FIXED_PRIO_EN defined: lowest active index wins, no pointer.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   i_req        request vector
//   i_adv        arbitration accepted this cycle (advance pointer)
//   o_win_oh     one-hot winner (all zero when no request)
//   o_win_idx    binary winner index
module jk_rr_arbiter
  import jk_cmd_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_adv,
  output logic [NREQ-1:0] o_win_oh,
  output logic [PW-1:0]   o_win_idx
);

  logic w_found;

`ifdef JK_ARB_FIXED_PRIO_EN
  logic w_unused;
  assign w_unused = ^{clk, rst_n, i_adv};

  // Scan high to low so the lowest active index is the last one written.
  always_comb begin
    o_win_oh  = '0;
    o_win_idx = '0;
    w_found   = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (i_req[k]) begin
        w_found   = 1'b1;
        o_win_idx = PW'(k);
      end
    end
    o_win_oh[o_win_idx] = w_found;
  end
`else
  logic [PW-1:0] r_ptr;

  // First active request at or after the pointer, wrapping around.
  always_comb begin
    o_win_oh  = '0;
    o_win_idx = '0;
    w_found   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(r_ptr) + k) % NREQ;
      if (!w_found && i_req[idx]) begin
        w_found   = 1'b1;
        o_win_idx = PW'(idx);
      end
    end
    o_win_oh[o_win_idx] = w_found;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_adv) begin
      r_ptr <= (o_win_idx == PW'(NREQ - 1)) ? '0 : o_win_idx + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/jk_cmd_arbiter.sv
// jk_cmd_arbiter: NREQ agents share one WIDTH-bit bank of JK bits.
// An IDLE cycle with any request arbitrates, latches the winner's op/mask
// and raises a one-cycle gnt/busy (APPLY); the following edge applies the
// op to the masked bits of q and returns to IDLE.
// Build option: JK_ARB_FIXED_PRIO_EN selects fixed lowest-index priority
// instead of round-robin.
// Ports:
//   clk       rising-edge clock
//   reset     async active-low reset
//   req       per-requester level request, held until granted
//   cmd_op    op of requester i at [2i+1:2i] ({j,k})
//   cmd_mask  mask of requester i at [WIDTH*i +: WIDTH]
//   gnt       registered one-hot grant, one cycle per command
//   busy      high during APPLY
//   q         JK bit bank
module jk_cmd_arbiter
  import jk_cmd_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     cmd_op,
  input  logic [WIDTH*NREQ-1:0] cmd_mask,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [WIDTH-1:0]      q
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t r_state, w_state_nxt;
  logic   w_arb;

  logic [NREQ-1:0][1:0]       w_op_arr;
  logic [NREQ-1:0][WIDTH-1:0] w_mask_arr;
  logic [NREQ-1:0]            w_win_oh;
  logic [PW-1:0]              w_win_idx;

  logic [NREQ-1:0]  r_gnt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;

  assign w_op_arr   = cmd_op;
  assign w_mask_arr = cmd_mask;

  jk_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .clk       (clk),
    .rst_n     (reset),
    .i_req     (req),
    .i_adv     (w_arb),
    .o_win_oh  (w_win_oh),
    .o_win_idx (w_win_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arb       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_arb       = 1'b1;
          w_state_nxt = ST_APPLY;
        end
      end
      ST_APPLY: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_q_nxt = r_q;
    for (int b = 0; b < WIDTH; b++) begin
      if (r_mask[b]) w_q_nxt[b] = jk_next(r_op, r_q[b]);
    end
  end

  // Command is latched at grant time, so a req dropped during APPLY
  // cannot cancel it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gnt  <= '0;
      r_op   <= OP_HOLD;
      r_mask <= '0;
      r_q    <= '0;
    end else if (w_arb) begin
      r_gnt  <= w_win_oh;
      r_op   <= w_op_arr[w_win_idx];
      r_mask <= w_mask_arr[w_win_idx];
    end else if (r_state == ST_APPLY) begin
      r_q    <= w_q_nxt;
      r_gnt  <= '0;
    end
  end

  assign gnt  = r_gnt;
  assign busy = (r_state == ST_APPLY);
  assign q    = r_q;

endmodule
